// File: rtl/core_isa_pkg.sv
// Shared ISA definitions for the per-core fetch/decode stages: word layout,
// opcode constants and instruction-length decoding.
package core_isa_pkg;

    localparam int unsigned MASK_LSB = 12;
    localparam int unsigned OPCODE_W = 12;

    typedef logic [OPCODE_W-1:0] opcode_t;

    localparam opcode_t OP_NOP   = 12'd0;
    localparam opcode_t OP_LOADA = 12'd3;
    localparam opcode_t OP_LOADB = 12'd5;
    localparam opcode_t OP_STORE = 12'd7;
    localparam opcode_t OP_JUMPZ = 12'd9;
    localparam opcode_t OP_JUMPN = 12'd13;
    localparam opcode_t OP_ENDOP = 12'd48;

    function automatic logic is_two_word(input opcode_t op);
        return (op == OP_LOADA) || (op == OP_LOADB) ||
               (op == OP_JUMPZ) || (op == OP_JUMPN);
    endfunction

    function automatic logic is_jump(input opcode_t op);
        return (op == OP_JUMPZ) || (op == OP_JUMPN);
    endfunction

endpackage

// File: rtl/core_fetch_decode.sv
// Per-core fetch/decode: walks the PC over the shared instruction memory, keeps
// instructions enabled for this core, assembles operands and issues them.
module core_fetch_decode
    import core_isa_pkg::*;
#(
    parameter int unsigned CORE_ID    = 0,
    parameter logic [15:0] START_ADDR = 16'd0
) (
    input  logic        clock,
    input  logic        reset,
    output logic [15:0] mem_addr,
    input  logic [15:0] mem_instr,
    output logic        dec_valid,
    input  logic        dec_ready,
    output logic [11:0] dec_opcode,
    output logic [15:0] dec_operand,
    output logic        dec_two_word,
    input  logic        jump_taken,
    output logic        halted
);

    localparam logic [3:0] EN_BIT = 4'(MASK_LSB + CORE_ID);

    typedef enum logic [2:0] {
        S_FETCH,
        S_INSTR,
        S_OPFETCH,
        S_OPND,
        S_ISSUE,
        S_HALT
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    opcode_t     opcode_q;
    logic [15:0] operand_q;
    logic        two_word_q;
    logic        local_q;
    logic        ir_ld;
    logic        opnd_ld;
    logic        instr_local;
    opcode_t     instr_op;

    assign instr_op    = mem_instr[OPCODE_W-1:0];
    assign instr_local = mem_instr[EN_BIT];

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_FETCH;
            pc_q    <= START_ADDR;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    // Operand length is taken from the opcode regardless of the mask, so a
    // foreign two-word instruction still consumes its operand slot.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_ld     = 1'b0;
        opnd_ld   = 1'b0;
        dec_valid = 1'b0;
        halted    = 1'b0;
        case (state_q)
            S_FETCH: state_d = S_INSTR;
            S_INSTR: begin
                ir_ld = 1'b1;
                pc_d  = pc_q + 16'd1;
                if (is_two_word(instr_op))    state_d = S_OPFETCH;
                else if (!instr_local)        state_d = S_FETCH;
                else if (instr_op == OP_ENDOP) state_d = S_HALT;
                else                          state_d = S_ISSUE;
            end
            S_OPFETCH: state_d = S_OPND;
            S_OPND: begin
                opnd_ld = 1'b1;
                pc_d    = pc_q + 16'd1;
                state_d = local_q ? S_ISSUE : S_FETCH;
            end
            S_ISSUE: begin
                dec_valid = 1'b1;
                if (dec_ready) begin
                    if (is_jump(opcode_q) && jump_taken) pc_d = operand_q;
                    state_d = S_FETCH;
                end
            end
            S_HALT:  halted = 1'b1;
            default: state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            opcode_q   <= '0;
            operand_q  <= '0;
            two_word_q <= 1'b0;
            local_q    <= 1'b0;
        end else begin
            if (ir_ld) begin
                opcode_q   <= instr_op;
                local_q    <= instr_local;
                two_word_q <= is_two_word(instr_op);
                operand_q  <= '0;
            end
            if (opnd_ld) operand_q <= mem_instr;
        end
    end

    assign mem_addr     = pc_q;
    assign dec_opcode   = opcode_q;
    assign dec_operand  = operand_q;
    assign dec_two_word = two_word_q;

endmodule

// File: doc/core_fetch_decode.md
# core_fetch_decode

Per-core instruction fetch and decode stage, sitting directly downstream of the shared 4-port instruction memory. One instance per core, on one memory read port. It walks the program counter, reads 16-bit words with the memory's one-cycle registered latency, and keeps only instructions whose core-enable bit selects this core. It assembles two-word instructions (opcode plus operand), presents them to the core's control unit over a valid/ready handshake, applies taken jumps, and halts on `endop`.

## Interface
Parameters:
- `CORE_ID`, default 0: core index 0..3; selects enable bit `12+CORE_ID` of each instruction word.
- `START_ADDR`, default 16'd0: PC value after reset (cores a/b/c/d use 0/15/30/46).

Ports:
- `clock`  in  1: sole clock, rising edge.
- `reset`  in  1: synchronous, active-high.
- `mem_addr`  out  16: read address to the instruction memory; always equals the internal PC register.
- `mem_instr`  in  16: memory data; valid the cycle after `mem_addr` was sampled.
- `dec_valid`  out  1: decoded instruction available.
- `dec_ready`  in  1: control unit accepts the instruction.
- `dec_opcode`  out  12: instruction bits [11:0].
- `dec_operand`  out  16: second word for two-word opcodes; 0 otherwise.
- `dec_two_word`  out  1: instruction carried an operand.
- `jump_taken`  in  1: sampled only on handshake of `jumpz`/`jumpn`; 1 = branch condition true.
- `halted`  out  1: `endop` for this core reached.

## Operation
- Word format: bits [15:12] are the core-enable mask (bit 12 = core a … bit 15 = core d); bits [11:0] are the opcode.
- Two-word opcodes: `loada`=3, `loadb`=5, `jumpz`=9, `jumpn`=13. All others, including `store`=7, are one word. `endop`=48.
- Operand words carry no mask. Their length comes from the opcode even when the instruction is masked out, so operands are always skipped with their opcode.
- States: FETCH, INSTR, OPFETCH, OPND, ISSUE, HALT.
  - FETCH: hold `mem_addr`; go to INSTR.
  - INSTR: latch `mem_instr` into IR; PC+1.
    - Two-word opcode: go to OPFETCH.
    - Else, mask bit clear: go to FETCH.
    - Else, opcode 48: go to HALT.
    - Else: go to ISSUE.
  - OPFETCH: go to OPND.
  - OPND: latch operand; PC+1. Mask bit set: go to ISSUE. Mask bit clear: go to FETCH.
  - ISSUE: `dec_valid`=1. On `dec_ready`:
    - If the opcode is 9 or 13 and `jump_taken`=1: PC ← operand.
    - Go to FETCH.
  - HALT: `halted`=1; PC frozen; exit only by reset.
- The stage does not interpret other opcodes; `nop` and unknown codes are issued unchanged.
- PC arithmetic is 16-bit modulo; 16'hFFFF+1 wraps to 0.

## Timing
- Reset values: `mem_addr`=START_ADDR, `dec_valid`=0, `dec_opcode`=0, `dec_operand`=0, `dec_two_word`=0, `halted`=0; state = FETCH.
- Reset has priority in every state, including mid-ISSUE and HALT. In the next cycle outputs take their reset values, and any pending instruction is dropped.
- Latency from the first non-reset edge:
  - One-word instruction: `dec_valid` is high after edge 2.
  - Two-word instruction: `dec_valid` is high after edge 4.
- Skipped words cost 2 cycles each; a skipped two-word instruction costs 4.
- Handshake:
  - `dec_opcode`, `dec_operand`, `dec_two_word` and `mem_addr` are stable while `dec_valid`=1 and `dec_ready`=0.
  - `dec_valid` drops the cycle after the handshake; there is no back-to-back issue.
- `dec_ready` while `dec_valid`=0 is ignored. `jump_taken` is ignored outside a jump handshake.
- `halted` rises in the cycle after INSTR decodes a local `endop`. `dec_valid` is never asserted for `endop`.

## Structure
- Shared package `core_isa_pkg` holds:
  - opcode constants (`loada`, `loadb`, `store`, `jumpz`, `jumpn`, `endop`, `nop`, …);
  - `MASK_LSB`=12 and `OPCODE_W`=12;
  - function `is_two_word(opcode)`.
- The state enum is local to the module.
- No sub-module; one FSM plus PC/IR/operand registers.

## Test plan
- **Basic load:** CORE_ID=0, START_ADDR=0, mem[0]=4099, mem[1]=0, mem[2]=4119, `dec_ready`=1 → first issue is opcode 3, operand 0, `dec_two_word`=1. Next issue is opcode 23, operand 0.
- **Masked skip:** CORE_ID=1, mem[0]=4099, mem[1]=8195, mem[2]=8196 → mem[1] is treated as an operand and skipped. The first issue is opcode 4 from address 2, visible after edge 6.
- **Jump:** CORE_ID=0, mem[13]=61449, mem[14]=63.
  - Handshake with `jump_taken`=1 → next `mem_addr`=63.
  - Repeat with `jump_taken`=0 → next `mem_addr`=15.
- **Backpressure:** hold `dec_ready`=0 for 5 cycles during ISSUE → `dec_valid`, `dec_opcode`, `dec_operand` and `mem_addr` are unchanged. Release → `dec_valid`=0 on the next cycle.
- **Halt:** mem[87]=4144.
  - CORE_ID=0 → `halted`=1, `mem_addr` stays 88, no issue.
  - CORE_ID=1 → word skipped, `mem_addr` advances to 88.
- **Reset and wrap:**
  - Reset asserted during ISSUE → next cycle `dec_valid`=0 and `mem_addr`=START_ADDR.
  - START_ADDR=16'hFFFF with mem[FFFF]=4143 → issue, then `mem_addr`=0.
